// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its write/read arbiter.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } arb_state_t;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit wider than address_t.
  typedef logic [5:0] count_t;

  localparam int unsigned REG_DEPTH = 2 ** $bits(address_t);

endpackage

// File: rtl/instr_reg_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin arbiter producing a one-hot grant.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant_c
);

  // When both request, the side that did not win last time is granted.
  always_comb begin
    grant_c = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant_c = 2'b01;
        2'b10:   grant_c = 2'b10;
        2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
        default: grant_c = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/instr_reg_arbiter.sv
// Shares the instruction register between two producers and drains it FIFO-style
// toward a single consumer; owns register reset sequencing and both pointers.
module instr_reg_arbiter
  import instr_register_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  opcode_t    req0_opcode,
  input  operand_t   req0_op_a,
  input  operand_t   req0_op_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  opcode_t    req1_opcode,
  input  operand_t   req1_op_a,
  input  operand_t   req1_op_b,
  output logic       req1_ready,
  input  logic       flush,
  input  logic       rd_pop,
  output logic       rd_valid,
  output logic       reg_reset_n,
  output logic       load_en,
  output address_t   write_pointer,
  output opcode_t    opcode,
  output operand_t   operand_a,
  output operand_t   operand_b,
  output address_t   read_pointer,
  output count_t     count,
  output logic       full,
  output logic       empty,
  output logic       grant
);

  localparam int unsigned CNT_W  = $bits(count_t);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  arb_state_t        state;
  logic [INIT_W-1:0] init_cnt;
  address_t          tail;
  logic [1:0]        gnt_c;
  logic              arb_en;
  logic              xfer;
  logic              pop;
  logic [SUM_W-1:0]  occ_sum;

  // Occupancy flags derived from registered count plus the write still in flight.
  assign occ_sum  = {1'b0, count} + SUM_W'(load_en);
  assign full     = (occ_sum == SUM_W'(DEPTH));
  assign empty    = (count == '0);
  assign rd_valid = (state == RUN) && (count != '0);
  assign pop      = rd_pop && rd_valid;

  assign arb_en = (state == RUN) && !flush && !full;

  rr_arbiter2 u_rr_arbiter2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (grant),
    .enable     (arb_en),
    .grant_c    (gnt_c)
  );

  assign req0_ready = gnt_c[0];
  assign req1_ready = gnt_c[1];
  assign xfer       = (gnt_c[0] && req0_valid) || (gnt_c[1] && req1_valid);

  // Sequencer: hold the register in reset for INIT_CYCLES, then run; flush lasts one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      reg_reset_n <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            state       <= RUN;
            reg_reset_n <= 1'b1;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        RUN:     if (flush) state <= FLUSH;
        FLUSH:   state <= RUN;
        default: state <= INIT;
      endcase
    end
  end

  // Write path: an accepted transfer becomes a one-cycle load_en to the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      grant         <= 1'b1;
    end else begin
      load_en <= xfer;
      if (xfer) begin
        write_pointer <= tail;
        grant         <= gnt_c[1];
        opcode        <= gnt_c[1] ? req1_opcode : req0_opcode;
        operand_a     <= gnt_c[1] ? req1_op_a   : req0_op_a;
        operand_b     <= gnt_c[1] ? req1_op_b   : req0_op_b;
      end
    end
  end

  // Pointers and occupancy; count follows the register commit, not the accept.
  always_ff @(posedge clk) begin
    if (reset || state == FLUSH) begin
      tail         <= '0;
      read_pointer <= '0;
      count        <= '0;
    end else begin
      if (xfer) tail <= tail + address_t'(1);
      if (pop)  read_pointer <= read_pointer + address_t'(1);
      case ({load_en, pop})
        2'b10:   count <= count + count_t'(1);
        2'b01:   count <= count - count_t'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_arbiter.sv
// Randomized and directed bench for instr_reg_arbiter with a queue-based reference model.
module tb_instr_reg_arbiter;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, req0_valid, req1_valid, flush, rd_pop;
  opcode_t req0_opcode, req1_opcode, opcode;
  operand_t req0_op_a, req0_op_b, req1_op_a, req1_op_b, operand_a, operand_b;
  logic req0_ready, req1_ready, rd_valid, reg_reset_n, load_en, full, empty, grant;
  address_t write_pointer, read_pointer;
  count_t count;

  instr_reg_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_op_a(req0_op_a),
    .req0_op_b(req0_op_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_op_a(req1_op_a),
    .req1_op_b(req1_op_b), .req1_ready(req1_ready),
    .flush(flush), .rd_pop(rd_pop), .rd_valid(rd_valid), .reg_reset_n(reg_reset_n),
    .load_en(load_en), .write_pointer(write_pointer), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .read_pointer(read_pointer),
    .count(count), .full(full), .empty(empty), .grant(grant)
  );

  // Stand-in for the instruction register storage.
  instruction_t reg_mem [32];
  always @(posedge clk) if (load_en) reg_mem[write_pointer] <= '{opcode, operand_a, operand_b};

  // Reference model: 0=init 1=run 2=flush; queue holds committed unread entries.
  int           m_phase, m_init_left, m_head, m_tail, m_last, m_pend_wp;
  bit           m_pend, m_rdy0, m_rdy1;
  instruction_t m_pend_d;
  instruction_t m_q[$];
  bit           i_r, i_v0, i_v1, i_f, i_p;
  instruction_t i_d0, i_d1;
  int checks = 0;
  int passes = 0;

  function automatic instruction_t rnd_ins();
    instruction_t d;
    d.opc  = opcode_t'($urandom_range(0, 7));
    d.op_a = operand_t'($urandom);
    d.op_b = operand_t'($urandom);
    return d;
  endfunction

  // Drive one cycle of inputs and derive the expected readies from the model.
  task automatic set_in(input bit r, v0, v1, f, p, input instruction_t d0, d1);
    bit en;
    i_r = r; i_v0 = v0; i_v1 = v1; i_f = f; i_p = p; i_d0 = d0; i_d1 = d1;
    reset = r; req0_valid = v0; req1_valid = v1; flush = f; rd_pop = p;
    req0_opcode = d0.opc; req0_op_a = d0.op_a; req0_op_b = d0.op_b;
    req1_opcode = d1.opc; req1_op_a = d1.op_a; req1_op_b = d1.op_b;
    en = (m_phase == 1) && !f && ((m_q.size() + int'(m_pend)) != 32);
    m_rdy0 = en && v0 && (!v1 || m_last == 1);
    m_rdy1 = en && v1 && (!v0 || m_last == 0);
    #1;
  endtask

  task automatic set_rnd(input bit r, v0, v1, f, p);
    set_in(r, v0, v1, f, p, rnd_ins(), rnd_ins());
  endtask

  // Take the clock edge and advance the model by the same cycle.
  task automatic advance();
    int old_phase;
    @(posedge clk);
    old_phase = m_phase;
    if (i_r) begin
      m_phase = 0; m_init_left = 2; m_q.delete(); m_head = 0; m_tail = 0;
      m_pend = 0; m_last = 1;
    end else begin
      if (i_p && m_phase == 1 && m_q.size() > 0) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % 32;
      end
      if (m_pend) m_q.push_back(m_pend_d);
      if (m_rdy0 && i_v0) begin
        m_pend = 1; m_pend_d = i_d0; m_pend_wp = m_tail; m_tail = (m_tail + 1) % 32; m_last = 0;
      end else if (m_rdy1 && i_v1) begin
        m_pend = 1; m_pend_d = i_d1; m_pend_wp = m_tail; m_tail = (m_tail + 1) % 32; m_last = 1;
      end else begin
        m_pend = 0;
      end
      if (old_phase == 2) begin
        m_q.delete(); m_head = 0; m_tail = 0;
      end
      case (old_phase)
        0: if (m_init_left == 1) m_phase = 1; else m_init_left--;
        1: if (i_f) m_phase = 2;
        default: m_phase = 1;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    set_rnd(1, 0, 0, 0, 0); advance();
    set_rnd(0, 0, 0, 0, 0); advance();
    set_rnd(0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_reset();
    set_rnd(1, 1, 1, 0, 0); advance();
    checks++; if (reg_reset_n !== 1'b0) $display("FAIL rst_reg_reset_n got %0b exp 0", reg_reset_n); else passes++;
    checks++; if (load_en !== 1'b0) $display("FAIL rst_load_en got %0b exp 0", load_en); else passes++;
    checks++; if (write_pointer !== 5'd0 || read_pointer !== 5'd0) $display("FAIL rst_ptrs got wp=%0d rp=%0d exp 0", write_pointer, read_pointer); else passes++;
    checks++; if (opcode !== ZERO || operand_a !== 0 || operand_b !== 0) $display("FAIL rst_data got %0d/%0d/%0d exp 0", opcode, operand_a, operand_b); else passes++;
    checks++; if (count !== 6'd0 || full !== 1'b0 || empty !== 1'b1) $display("FAIL rst_flags got c=%0d f=%0b e=%0b exp 0/0/1", count, full, empty); else passes++;
    checks++; if (rd_valid !== 1'b0 || grant !== 1'b1) $display("FAIL rst_rv_grant got rv=%0b g=%0b exp 0/1", rd_valid, grant); else passes++;
    for (int c = 0; c < 2; c++) begin
      set_rnd(0, 1, 1, 0, 0);
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL init_ready got %0b%0b exp 00", req1_ready, req0_ready); else passes++;
      advance();
      checks++; if (reg_reset_n !== (c == 1)) $display("FAIL init_reg_reset_n cyc %0d got %0b exp %0b", c, reg_reset_n, c == 1); else passes++;
    end
  endtask

  task automatic test_single();
    instruction_t w;
    w = '{ADD, 32'sd5, 32'sd3};
    set_in(0, 1, 0, 0, 0, w, rnd_ins());
    checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready got %0b exp 1", req0_ready); else passes++;
    advance();
    checks++; if (load_en !== 1'b1 || write_pointer !== 5'd0 || count !== 6'd0) $display("FAIL single_load got le=%0b wp=%0d c=%0d exp 1/0/0", load_en, write_pointer, count); else passes++;
    set_rnd(0, 0, 0, 0, 0); advance();
    checks++; if (count !== 6'd1 || rd_valid !== 1'b1 || read_pointer !== 5'd0 || load_en !== 1'b0) $display("FAIL single_commit got c=%0d rv=%0b rp=%0d le=%0b exp 1/1/0/0", count, rd_valid, read_pointer, load_en); else passes++;
    checks++; if (reg_mem[read_pointer].opc !== ADD || (reg_mem[read_pointer].op_a + reg_mem[read_pointer].op_b) !== 8) $display("FAIL single_result got %0d exp 8", reg_mem[read_pointer].op_a + reg_mem[read_pointer].op_b); else passes++;
    set_rnd(0, 0, 0, 0, 1); advance();
    checks++; if (empty !== 1'b1 || read_pointer !== 5'd1) $display("FAIL single_pop got e=%0b rp=%0d exp 1/1", empty, read_pointer); else passes++;
  endtask

  task automatic test_contention();
    instruction_t sent [4];
    instruction_t d0, d1;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      d0 = rnd_ins(); d1 = rnd_ins();
      sent[c] = (c % 2 == 0) ? d0 : d1;
      set_in(0, 1, 1, 0, 0, d0, d1);
      checks++; if (req0_ready !== (c % 2 == 0) || req1_ready !== (c % 2 == 1)) $display("FAIL cont_ready cyc %0d got %0b%0b", c, req1_ready, req0_ready); else passes++;
      advance();
      checks++; if (grant !== 1'(c % 2) || write_pointer !== 5'(c) || load_en !== 1'b1) $display("FAIL cont_write cyc %0d got g=%0b wp=%0d le=%0b exp %0d/%0d/1", c, grant, write_pointer, load_en, c % 2, c); else passes++;
    end
    set_rnd(0, 0, 0, 0, 0); advance();
    for (int c = 0; c < 4; c++) begin
      set_rnd(0, 0, 0, 0, 1);
      checks++; if (read_pointer !== 5'(c) || reg_mem[read_pointer] !== sent[c]) $display("FAIL cont_read %0d got rp=%0d d=%h exp %0d/%h", c, read_pointer, reg_mem[read_pointer], c, sent[c]); else passes++;
      advance();
    end
  endtask

  task automatic test_full_wrap();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      set_rnd(0, 1, 0, 0, 0);
      if (req0_ready !== 1'b1) bad++;
      advance();
    end
    checks++; if (bad != 0) $display("FAIL fill_ready got %0d stalls exp 0", bad); else passes++;
    set_rnd(0, 1, 0, 0, 0);
    checks++; if (full !== 1'b1 || req0_ready !== 1'b0) $display("FAIL full_inflight got f=%0b r=%0b exp 1/0", full, req0_ready); else passes++;
    advance();
    checks++; if (count !== 6'd32 || full !== 1'b1) $display("FAIL full_count got c=%0d f=%0b exp 32/1", count, full); else passes++;
    set_rnd(0, 1, 0, 0, 1);
    checks++; if (req0_ready !== 1'b0 || rd_valid !== 1'b1) $display("FAIL full_pop got r=%0b rv=%0b exp 0/1", req0_ready, rd_valid); else passes++;
    advance();
    set_rnd(0, 1, 0, 0, 0);
    checks++; if (req0_ready !== 1'b1 || count !== 6'd31) $display("FAIL wrap_ready got r=%0b c=%0d exp 1/31", req0_ready, count); else passes++;
    advance();
    checks++; if (write_pointer !== 5'd0 || load_en !== 1'b1) $display("FAIL wrap_wp got wp=%0d le=%0b exp 0/1", write_pointer, load_en); else passes++;
    set_rnd(0, 0, 0, 0, 0); advance();
    checks++; if (count !== 6'd32 || full !== 1'b1) $display("FAIL wrap_count got c=%0d f=%0b exp 32/1", count, full); else passes++;
  endtask

  task automatic test_simul_pop();
    do_reset();
    for (int c = 0; c < 5; c++) begin set_rnd(0, 1, 0, 0, 0); advance(); end
    set_rnd(0, 0, 0, 0, 0); advance();
    set_rnd(0, 1, 0, 0, 0); advance();
    checks++; if (count !== 6'd5 || load_en !== 1'b1) $display("FAIL simul_pre got c=%0d le=%0b exp 5/1", count, load_en); else passes++;
    set_rnd(0, 0, 0, 0, 1); advance();
    checks++; if (count !== 6'd5 || read_pointer !== 5'd1) $display("FAIL simul_commit_pop got c=%0d rp=%0d exp 5/1", count, read_pointer); else passes++;
    for (int c = 0; c < 5; c++) begin set_rnd(0, 0, 0, 0, 1); advance(); end
    set_rnd(0, 0, 0, 0, 1); advance();
    checks++; if (read_pointer !== 5'd6 || count !== 6'd0 || empty !== 1'b1) $display("FAIL pop_empty got rp=%0d c=%0d e=%0b exp 6/0/1", read_pointer, count, empty); else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin set_rnd(0, 1, 0, 0, 0); advance(); end
    set_rnd(0, 1, 0, 1, 0);
    checks++; if (req0_ready !== 1'b0 || load_en !== 1'b1) $display("FAIL flush_req got r=%0b le=%0b exp 0/1", req0_ready, load_en); else passes++;
    advance();
    set_rnd(0, 1, 0, 0, 0);
    checks++; if (req0_ready !== 1'b0 || rd_valid !== 1'b0) $display("FAIL flush_cycle got r=%0b rv=%0b exp 0/0", req0_ready, rd_valid); else passes++;
    advance();
    checks++; if (count !== 6'd0 || empty !== 1'b1 || read_pointer !== 5'd0) $display("FAIL flush_clear got c=%0d e=%0b rp=%0d exp 0/1/0", count, empty, read_pointer); else passes++;
    set_rnd(0, 1, 0, 0, 0); advance();
    checks++; if (load_en !== 1'b1 || write_pointer !== 5'd0) $display("FAIL flush_next_wp got le=%0b wp=%0d exp 1/0", load_en, write_pointer); else passes++;
  endtask

  task automatic test_reset_mid();
    set_rnd(0, 1, 1, 0, 0); advance();
    set_rnd(1, 1, 0, 0, 0); advance();
    checks++; if (load_en !== 1'b0 || count !== 6'd0 || reg_reset_n !== 1'b0) $display("FAIL reset_mid got le=%0b c=%0d rrn=%0b exp 0/0/0", load_en, count, reg_reset_n); else passes++;
    set_rnd(0, 1, 1, 0, 0);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_mid_init got %0b%0b exp 00", req1_ready, req0_ready); else passes++;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      set_rnd($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      checks++; if (req0_ready !== m_rdy0 || req1_ready !== m_rdy1) $display("FAIL rnd_ready cyc %0d got %0b%0b exp %0b%0b", c, req1_ready, req0_ready, m_rdy1, m_rdy0); else passes++;
      advance();
      checks++; if (load_en !== m_pend || reg_reset_n !== (m_phase != 0) || grant !== 1'(m_last)) $display("FAIL rnd_ctrl cyc %0d got le=%0b rrn=%0b g=%0b exp %0b/%0b/%0d", c, load_en, reg_reset_n, grant, m_pend, m_phase != 0, m_last); else passes++;
      checks++; if (count !== 6'(m_q.size()) || read_pointer !== 5'(m_head) || empty !== (m_q.size() == 0) || full !== ((m_q.size() + int'(m_pend)) == 32)) $display("FAIL rnd_occ cyc %0d got c=%0d rp=%0d e=%0b f=%0b exp c=%0d rp=%0d", c, count, read_pointer, empty, full, m_q.size(), m_head); else passes++;
      checks++; if (rd_valid !== (m_phase == 1 && m_q.size() != 0)) $display("FAIL rnd_rd_valid cyc %0d got %0b", c, rd_valid); else passes++;
      if (m_pend) begin
        checks++; if (write_pointer !== 5'(m_pend_wp) || opcode !== m_pend_d.opc || operand_a !== m_pend_d.op_a || operand_b !== m_pend_d.op_b) $display("FAIL rnd_wdata cyc %0d got wp=%0d exp %0d", c, write_pointer, m_pend_wp); else passes++;
      end
      if (m_phase == 1 && m_q.size() != 0) begin
        checks++; if (reg_mem[read_pointer] !== m_q[0]) $display("FAIL rnd_rdata cyc %0d got %h exp %h", c, reg_mem[read_pointer], m_q[0]); else passes++;
      end
    end
  endtask

  initial begin
    m_phase = 0; m_init_left = 2; m_head = 0; m_tail = 0; m_last = 1; m_pend = 0; m_pend_wp = 0;
    set_rnd(0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_full_wrap();
    test_simul_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_reg_arbiter.md
Name: instr_reg_arbiter

Overview:
- Controller that shares the 32-entry instruction register between two instruction producers and drains it in FIFO order toward one consumer.
- Sequences the register's reset, arbitrates writes round-robin, and generates load_en and write_pointer.
- Tracks occupancy and drives read_pointer to the oldest written entry.
- Sits directly in front of the instr_register instance in place of testbench-driven pointers.

Parameters:
- DEPTH, 32, number of register entries; must equal 2**$bits(address_t).
- INIT_CYCLES, 2, cycles reg_reset_n is held low after reset.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an instruction
- req0_opcode  input  opcode_t  requester 0 opcode
- req0_op_a  input  operand_t  requester 0 operand A
- req0_op_b  input  operand_t  requester 0 operand B
- req0_ready  output  1  requester 0 transfer accepted this cycle
- req1_valid / req1_opcode / req1_op_a / req1_op_b / req1_ready: same as requester 0.
- flush  input  1  discard all stored entries
- rd_pop  input  1  consumer has taken the entry at read_pointer
- rd_valid  output  1  read_pointer addresses a written, unread entry
- reg_reset_n  output  1  active-low reset to instruction register
- load_en  output  1  register write enable
- write_pointer  output  address_t  register write address
- opcode  output  opcode_t  register write data
- operand_a  output  operand_t  register write data
- operand_b  output  operand_t  register write data
- read_pointer  output  address_t  register read address (head)
- count  output  6  written, unread entries, 0..32
- full  output  1  no free slot, counting the in-flight write
- empty  output  1  count==0
- grant  output  1  index of last accepted requester

Clock and reset as above (already decided): one clock, clk; reset is synchronous and active-high, port named reset.

Behaviour:
- Reset values: state INIT; reg_reset_n=0; load_en=0; write_pointer=0; read_pointer=0; opcode=ZERO; operands=0; count=0; full=0; empty=1; rd_valid=0; ready=0; grant=1, so req0 wins first.
- A pending write is dropped when reset is asserted mid-operation.
- FSM INIT: reg_reset_n=0, readies 0. After INIT_CYCLES cycles go to RUN; reg_reset_n=1 from the first RUN cycle.
- FSM RUN: arbitration active.
  - flush=1 forces both readies 0 and moves to FLUSH.
- FSM FLUSH, one cycle: readies 0; head, tail and count cleared at its end edge.
  - A load_en issued in the previous cycle still completes its register write but is not counted.
  - Returns to RUN.
- Arbitration (combinational, RUN only, !full):
  - Exactly one valid requester is granted.
  - Both valid: the requester != grant wins.
  - reqN_ready = granted; a transfer is valid&&ready.
- Write latency: on the transfer edge, capture opcode/op_a/op_b, write_pointer=tail, load_en=1 for exactly one cycle, tail++ (mod 32), grant=winner.
  - The register writes at the following edge, and count increments at that same edge.
  - Back-to-back transfers are allowed: load_en stays high and pointers advance every cycle.
- Read:
  - read_pointer=head.
  - rd_valid = (count!=0) in RUN.
  - rd_pop && rd_valid: head++ (mod 32), count-- at the edge.
  - rd_pop when !rd_valid is ignored.
- Simultaneous load_en write commit and pop: count unchanged.
- full = (count + load_en == DEPTH); empty = (count==0). Both come from registered state.
- Pointers wrap 31→0 silently. Overflow is impossible because ready=0 when full.

Decomposition:
- instr_register_pkg gains: an arb_state_t enum (INIT, RUN, FLUSH) and a count_t typedef (6-bit).
- opcode_t, operand_t and address_t are reused from instr_register_pkg.
- One sub-module: rr_arbiter2. It is a combinational 2-way round-robin taking valid[1:0], last grant and enable, and producing one-hot grant.

Test Plan:
- Reset release: reset 1 for 1 cycle, then 0 → reg_reset_n low exactly 2 cycles, then high; all readies 0 during INIT.
- Single write/read: req0 {ADD,5,3} → load_en pulse at write_pointer=0 one cycle after accept; count 1, rd_valid=1, read_pointer=0; instruction_word.rezultat=8; rd_pop → empty=1.
- Contention: both valid for 4 cycles → grants 0,1,0,1; write_pointers 0,1,2,3; reads return entries in that order.
- Full/wrap: 32 writes with no pop → full=1 and readies 0. Then 1 pop followed by 1 write → write_pointer=0 (wrap), count=32.
- Simultaneous commit+pop at count=5 → count stays 5; pop on empty → head unchanged.
- Flush mid-stream with a write in flight → count=0, empty=1, read_pointer=0. The next accepted write goes to write_pointer=0.
- Reset mid-stream: reset asserted on an accept cycle → load_en=0 next cycle, count=0, FSM back in INIT.
